// File: rtl/tx_encode_pkg.sv
// Shared definitions for the transmit symbol encoder: FSM states, PAM5
// level codes, delimiter words, scrambler taps and the lane-map helpers.
package tx_encode_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SSD1 = 3'd1,
    ST_SSD2 = 3'd2,
    ST_DATA = 3'd3,
    ST_ESD1 = 3'd4,
    ST_ESD2 = 3'd5
  } tx_state_e;

  // PAM5 levels as 3-bit two's complement
  localparam logic [2:0] PAM5_M2 = 3'b110;
  localparam logic [2:0] PAM5_M1 = 3'b111;
  localparam logic [2:0] PAM5_Z  = 3'b000;
  localparam logic [2:0] PAM5_P1 = 3'b001;
  localparam logic [2:0] PAM5_P2 = 3'b010;

  // Delimiter words, lane3 in the top bits
  localparam logic [11:0] SYM_SSD1 = {PAM5_P2, PAM5_P2, PAM5_P2, PAM5_P2};
  localparam logic [11:0] SYM_SSD2 = {PAM5_M2, PAM5_P2, PAM5_P2, PAM5_P2};
  localparam logic [11:0] SYM_ESD1 = {PAM5_P2, PAM5_P2, PAM5_P2, PAM5_P2};
  localparam logic [11:0] SYM_ESD2 = {PAM5_P2, PAM5_M2, PAM5_P2, PAM5_P2};

  // Side-stream scrambler: s[n] = s[n-13] ^ s[n-33]
  localparam int LFSR_LEN   = 33;
  localparam int LFSR_TAP_A = 13;
  localparam int LFSR_TAP_B = 33;

  // One lane: two data bits plus trellis parity to a PAM5 level
  function automatic logic [2:0] pam5_lane(input logic [1:0] b, input logic p);
    logic [2:0] lvl;
    lvl = PAM5_Z;
    case ({p, b})
      3'b000:  lvl = PAM5_M2;
      3'b001:  lvl = PAM5_M1;
      3'b010:  lvl = PAM5_P1;
      3'b011:  lvl = PAM5_P2;
      3'b100:  lvl = PAM5_M1;
      3'b101:  lvl = PAM5_Z;
      3'b110:  lvl = PAM5_P1;
      3'b111:  lvl = PAM5_P2;
      default: lvl = PAM5_Z;
    endcase
    return lvl;
  endfunction

  // Four lanes: lane k takes sd[2k+1:2k] and lands at [3k+2:3k]
  function automatic logic [11:0] pam5_word(input logic [7:0] sd, input logic p);
    logic [11:0] w;
    w = 12'h000;
    for (int k = 0; k < 4; k++) begin
      w[3*k +: 3] = pam5_lane(sd[2*k +: 2], p);
    end
    return w;
  endfunction

endpackage

// File: rtl/tx_scrambler33.sv
// 33-bit side-stream LFSR producing 8 new sequence bits per cycle.
// r_lfsr[0] holds the oldest bit s[n-33], r_lfsr[32] the newest s[n-1].
import tx_encode_pkg::*;

module tx_scrambler33 #(
  parameter logic [32:0] SEED = 33'h1DEADBEEF
) (
  input  logic       clock,
  input  logic       reset,
  output logic [7:0] o_scr
);

  logic [32:0] r_lfsr;
  logic [7:0]  w_new;

  // Next 8 bits; both taps stay inside the current window for 8 steps ahead
  always_comb begin
    w_new = 8'h00;
    for (int j = 0; j < 8; j++) begin
      w_new[j] = r_lfsr[j + LFSR_LEN - LFSR_TAP_A] ^ r_lfsr[j + LFSR_LEN - LFSR_TAP_B];
    end
  end

  // Slide the window by one byte each cycle, or return to seed under reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= {w_new, r_lfsr[32:8]};
    end
  end

  assign o_scr = w_new;

endmodule

// File: rtl/tx_symbol_encoder.sv
// Transmit symbol encoder: frames a byte stream with SSD/ESD delimiters,
// scrambles it, adds one trellis parity bit and maps it onto 4 PAM5 lanes.
import tx_encode_pkg::*;

module tx_symbol_encoder #(
  parameter logic [32:0] SCR_SEED   = 33'h1DEADBEEF,
  parameter int unsigned IPG_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_in_valid,
  input  logic [7:0]  io_in_bits,
  input  logic        io_in_last,
  output logic        io_in_ready,
  output logic [11:0] io_txSymbols,
  output logic        io_txValid,
  output logic        io_underrun
);

  localparam logic [3:0] IPG_RELOAD = 4'(IPG_CYCLES);

  tx_state_e   r_state, w_state_next;
  logic [2:0]  r_cs, w_cs_next;
  logic [3:0]  r_ipg, w_ipg_next;
  logic        r_underrun_pend;
  logic [7:0]  w_scr;
  logic [7:0]  w_sd;
  logic        w_p;
  logic [11:0] w_sym;
  logic [11:0] r_tx_symbols;
  logic        r_tx_valid;
  logic        r_underrun;

  tx_scrambler33 #(.SEED(SCR_SEED)) u_scrambler (
    .clock (clock),
    .reset (reset),
    .o_scr (w_scr)
  );

  // FSM state, trellis state, inter-packet gap counter and abort memory
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state         <= ST_IDLE;
      r_cs            <= 3'b000;
      r_ipg           <= IPG_RELOAD;
      r_underrun_pend <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_cs            <= w_cs_next;
      r_ipg           <= w_ipg_next;
      r_underrun_pend <= (r_state == ST_DATA) && !io_in_valid;
    end
  end

  // Next state, symbol selection and trellis update
  always_comb begin
    w_state_next = r_state;
    w_cs_next    = r_cs;
    w_ipg_next   = r_ipg;
    w_sd         = w_scr;
    w_p          = 1'b0;
    w_sym        = 12'h000;
    case (r_state)
      ST_IDLE: begin
        w_cs_next  = 3'b000;
        w_ipg_next = (r_ipg == 4'd0) ? 4'd0 : (r_ipg - 4'd1);
        w_sym      = pam5_word(w_scr, 1'b0);
        if (io_in_valid && (r_ipg == 4'd0)) begin
          w_state_next = ST_SSD1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_SSD1: begin
        w_sym        = SYM_SSD1;
        w_state_next = ST_SSD2;
      end
      ST_SSD2: begin
        w_sym        = SYM_SSD2;
        w_state_next = ST_DATA;
      end
      ST_DATA: begin
        w_sd      = io_in_bits ^ w_scr;
        w_p       = r_cs[0];
        w_sym     = pam5_word(w_sd, w_p);
        w_cs_next = {w_sd[6] ^ r_cs[0], r_cs[2], r_cs[1] ^ w_sd[7]};
        // Missing byte aborts the frame; last byte closes it normally
        if (!io_in_valid || io_in_last) begin
          w_state_next = ST_ESD1;
        end else begin
          w_state_next = ST_DATA;
        end
      end
      ST_ESD1: begin
        w_sym        = SYM_ESD1;
        w_state_next = ST_ESD2;
      end
      ST_ESD2: begin
        w_sym        = SYM_ESD2;
        w_ipg_next   = IPG_RELOAD;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_cs_next    = 3'b000;
        w_ipg_next   = IPG_RELOAD;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Output word register; underrun flag rides with the ESD1 symbol
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_tx_symbols <= 12'h000;
      r_tx_valid   <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_tx_symbols <= w_sym;
      r_tx_valid   <= 1'b1;
      r_underrun   <= (r_state == ST_ESD1) && r_underrun_pend;
    end
  end

  assign io_in_ready  = reset && (r_state == ST_DATA);
  assign io_txSymbols = r_tx_symbols;
  assign io_txValid   = r_tx_valid;
  assign io_underrun  = r_underrun;

endmodule

// File: tb/tb_tx_symbol_encoder.sv
// Self-checking bench for tx_symbol_encoder: a directed vector table,
// hand-written frame sequences and randomized traffic, all scored against
// a bit-serial reference model of the scrambler/trellis/lane mapping.
module tb_tx_symbol_encoder;

  localparam logic [32:0] SEED = 33'h1DEADBEEF;
  localparam int          IPG  = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_bits;
  logic        in_last;
  logic        in_ready;
  logic [11:0] tx_symbols;
  logic        tx_valid;
  logic        underrun;

  tx_symbol_encoder #(.SCR_SEED(SEED), .IPG_CYCLES(IPG)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (in_valid),
    .io_in_bits   (in_bits),
    .io_in_last   (in_last),
    .io_in_ready  (in_ready),
    .io_txSymbols (tx_symbols),
    .io_txValid   (tx_valid),
    .io_underrun  (underrun)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  bit         m_s[$];      // recent scrambler sequence bits, oldest first
  int         m_phase;     // 0 idle,1 ssd1,2 ssd2,3 data,4 esd1,5 esd2
  bit [2:0]   m_cs;
  int         m_ipg;
  bit         m_abort;
  logic [11:0] e_sym;
  logic        e_valid;
  logic        e_under;

  function automatic void m_init();
    m_s.delete();
    for (int i = 0; i < 33; i++) m_s.push_back(SEED[i]);
    m_phase = 0;
    m_cs    = 3'b000;
    m_ipg   = IPG;
    m_abort = 1'b0;
  endfunction

  function automatic bit [7:0] m_next_scr();
    bit [7:0] b;
    int       n;
    bit       x;
    b = 8'h00;
    for (int j = 0; j < 8; j++) begin
      n = m_s.size();
      x = m_s[n-13] ^ m_s[n-33];
      m_s.push_back(x);
      b[j] = x;
    end
    while (m_s.size() > 40) void'(m_s.pop_front());
    return b;
  endfunction

  // level = dibit value shifted onto the PAM5 alphabet
  function automatic logic [11:0] m_word(input bit [7:0] sd, input bit p);
    logic [11:0] w;
    int          v;
    int          b;
    w = 12'h000;
    for (int k = 0; k < 4; k++) begin
      b = int'(sd[2*k +: 2]);
      if (p) v = b - 1;
      else   v = b - 2 + ((b >= 2) ? 1 : 0);
      w[3*k +: 3] = 3'(v);
    end
    return w;
  endfunction

  function automatic void m_step();
    bit [7:0] scr;
    bit [7:0] sd;
    if (!reset) begin
      m_init();
      e_sym = 12'h000; e_valid = 1'b0; e_under = 1'b0;
      return;
    end
    scr     = m_next_scr();
    e_valid = 1'b1;
    e_under = 1'b0;
    case (m_phase)
      0: begin
        e_sym = m_word(scr, 1'b0);
        m_cs  = 3'b000;
        if (in_valid && m_ipg == 0) m_phase = 1;
        else if (m_ipg > 0)         m_ipg   = m_ipg - 1;
      end
      1: begin e_sym = 12'h492; m_phase = 2; end
      2: begin e_sym = 12'hC92; m_phase = 3; end
      3: begin
        sd    = in_bits ^ scr;
        e_sym = m_word(sd, m_cs[0]);
        m_cs  = {sd[6] ^ m_cs[0], m_cs[2], m_cs[1] ^ sd[7]};
        if (!in_valid) begin m_abort = 1'b1; m_phase = 4; end
        else if (in_last) m_phase = 4;
      end
      4: begin e_sym = 12'h492; e_under = m_abort; m_abort = 1'b0; m_phase = 5; end
      default: begin e_sym = 12'h592; m_phase = 0; m_ipg = IPG; end
    endcase
  endfunction

  // ---------------- checking / capture ----------------
  logic [11:0] q_out[$];
  bit          q_rdy[$];
  bit          q_und[$];
  int          hs_idx[$];
  int          cyc = 0;
  bit          last_hs;
  bit          last_rdy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void clear_caps();
    q_out.delete(); q_rdy.delete(); q_und.delete(); hs_idx.delete();
  endfunction

  // One clock: inputs were just set at the falling edge
  task automatic tick();
    #1;
    last_rdy = in_ready;
    check("ready", 32'(in_ready), 32'((m_phase == 3) && reset));
    last_hs = in_valid && in_ready;
    if (last_hs) hs_idx.push_back(cyc);
    q_rdy.push_back(in_ready);
    @(posedge clock);
    m_step();
    #1;
    check("symbols", 32'(tx_symbols), 32'(e_sym));
    check("txValid", 32'(tx_valid), 32'(e_valid));
    check("underrun", 32'(underrun), 32'(e_under));
    q_out.push_back(tx_symbols);
    q_und.push_back(underrun);
    cyc++;
    @(negedge clock);
  endtask

  task automatic drive(input bit r, input bit v, input bit [7:0] b, input bit l);
    reset = r; in_valid = v; in_bits = b; in_last = l;
    tick();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit        rst_n;
    bit        valid;
    bit [7:0]  bits;
    bit        last;
    bit        exp_ready;
    bit        chk_sym;
    bit [11:0] exp_sym;
    bit        exp_txv;
    bit        exp_under;
  } vec_t;

  vec_t tbl[$];

  function automatic void add_vec(input bit r, input bit v, input bit [7:0] b, input bit l,
                                  input bit er, input bit cs, input bit [11:0] es,
                                  input bit ev, input bit eu);
    vec_t t;
    t.rst_n = r; t.valid = v; t.bits = b; t.last = l;
    t.exp_ready = er; t.chk_sym = cs; t.exp_sym = es; t.exp_txv = ev; t.exp_under = eu;
    tbl.push_back(t);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] g0;
    int          cnt;
    int          k;
    int          sent;

    // golden first IDLE word after reset
    m_init();
    g0 = m_word(m_next_scr(), 1'b0);
    m_init();

    for (int i = 0; i < 3; i++) add_vec(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0);
    add_vec(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, g0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) add_vec(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
    add_vec(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
    add_vec(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 12'h492, 1'b1, 1'b0);
    add_vec(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 12'hC92, 1'b1, 1'b0);
    add_vec(1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 12'h000, 1'b1, 1'b0);
    add_vec(1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 12'h000, 1'b1, 1'b0);
    add_vec(1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 12'h000, 1'b1, 1'b0);
    add_vec(1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 1'b0);
    add_vec(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 12'h492, 1'b1, 1'b0);
    add_vec(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 12'h592, 1'b1, 1'b0);
    add_vec(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
    add_vec(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0);

    // reset + 4-byte frame from the table
    clear_caps();
    foreach (tbl[i]) begin
      drive(tbl[i].rst_n, tbl[i].valid, tbl[i].bits, tbl[i].last);
      check("tbl_ready", 32'(last_rdy), 32'(tbl[i].exp_ready));
      check("tbl_txValid", 32'(tx_valid), 32'(tbl[i].exp_txv));
      check("tbl_underrun", 32'(underrun), 32'(tbl[i].exp_under));
      if (tbl[i].chk_sym) check("tbl_symbols", 32'(tx_symbols), 32'(tbl[i].exp_sym));
    end
    cnt = 0;
    foreach (q_rdy[i]) cnt += int'(q_rdy[i]);
    check("frame4_ready_cycles", 32'(cnt), 32'd4);
    check("frame4_handshakes", 32'(hs_idx.size()), 32'd4);

    // underrun after 2 of 5 bytes
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'h00, 1'b0);
    clear_caps();
    drive(1'b1, 1'b1, 8'h11, 1'b0);
    drive(1'b1, 1'b1, 8'h11, 1'b0);
    drive(1'b1, 1'b1, 8'h11, 1'b0);
    drive(1'b1, 1'b1, 8'h11, 1'b0);
    drive(1'b1, 1'b1, 8'h22, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'h33, 1'b0);
    cnt = 0; k = -1;
    foreach (q_und[i]) if (q_und[i]) begin cnt++; k = i; end
    check("underrun_pulses", 32'(cnt), 32'd1);
    check("underrun_handshakes", 32'(hs_idx.size()), 32'd2);
    if (k >= 0 && k + 1 < q_out.size()) begin
      check("underrun_with_esd1", 32'(q_out[k]), 32'h492);
      check("underrun_then_esd2", 32'(q_out[k+1]), 32'h592);
    end else begin
      check("underrun_position_found", 32'd0, 32'd1);
    end

    // back-to-back 2-byte frames with source always valid
    clear_caps();
    sent = 0;
    for (int c = 0; c < 40; c++) begin
      drive(1'b1, 1'b1, 8'(8'h40 + 8'(c)), (sent == 1));
      if (last_hs) sent = (sent == 1) ? 0 : 1;
    end
    check("b2b_enough_frames", 32'(hs_idx.size() >= 4), 32'd1);
    if (hs_idx.size() >= 4) begin
      check("b2b_in_frame_adjacent", 32'(hs_idx[1] - hs_idx[0]), 32'd1);
      check("b2b_ipg_respected", 32'(hs_idx[2] - hs_idx[1] >= 9), 32'd1);
    end

    // reset pulse during DATA byte 2
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 8'h00, 1'b0);
    clear_caps();
    drive(1'b1, 1'b1, 8'h77, 1'b0);
    drive(1'b1, 1'b1, 8'h77, 1'b0);
    drive(1'b1, 1'b1, 8'h77, 1'b0);
    drive(1'b1, 1'b1, 8'h77, 1'b0);
    drive(1'b0, 1'b1, 8'h88, 1'b0);
    check("midreset_symbols", 32'(tx_symbols), 32'h000);
    check("midreset_txValid", 32'(tx_valid), 32'd0);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    check("midreset_seed_restart", 32'(tx_symbols), 32'(g0));
    check("midreset_txValid_back", 32'(tx_valid), 32'd1);

    // single-byte frame
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'h00, 1'b0);
    clear_caps();
    drive(1'b1, 1'b1, 8'h5A, 1'b1);
    drive(1'b1, 1'b1, 8'h5A, 1'b1);
    drive(1'b1, 1'b1, 8'h5A, 1'b1);
    drive(1'b1, 1'b1, 8'h5A, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'h00, 1'b0);
    cnt = 0; k = -1;
    foreach (q_rdy[i]) if (q_rdy[i]) begin cnt++; k = i; end
    check("single_ready_cycles", 32'(cnt), 32'd1);
    if (k >= 1 && k + 2 < q_out.size()) begin
      check("single_before_ssd2", 32'(q_out[k-1]), 32'hC92);
      check("single_after_esd1", 32'(q_out[k+1]), 32'h492);
      check("single_then_esd2", 32'(q_out[k+2]), 32'h592);
    end else begin
      check("single_position_found", 32'd0, 32'd1);
    end

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      drive(($urandom_range(0, 199) != 0), ($urandom_range(0, 7) != 0),
            8'($urandom_range(0, 255)), ($urandom_range(0, 5) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
